// File: rtl/axi_std_master_pkg.sv
// Shared types and constants for the AXI4 standard master.
// Optional feature macro: AXI_MST_ERR_CHECK_EN (response / RLAST error tracking).
package axi_std_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WDATA,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } axi_mst_state_t;

   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
   localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

   // AxSIZE encoding for a full-width beat of the given data width in bits
   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/axi_std_master_if.sv
// AXI4 full-protocol bus bundle (USER signals omitted) with master/slave views.
interface axi_std_master_if #(
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_M_AXI_ADDR_WIDTH = 10
);

   // write address channel
   logic [C_M_AXI_ID_WIDTH-1:0]       awid;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr;
   logic [7:0]                        awlen;
   logic [2:0]                        awsize;
   logic [1:0]                        awburst;
   logic                              awlock;
   logic [3:0]                        awcache;
   logic [2:0]                        awprot;
   logic [3:0]                        awqos;
   logic [3:0]                        awregion;
   logic                              awvalid;
   logic                              awready;

   // write data channel
   logic [C_M_AXI_DATA_WIDTH-1:0]     wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb;
   logic                              wlast;
   logic                              wvalid;
   logic                              wready;

   // write response channel
   logic [C_M_AXI_ID_WIDTH-1:0]       bid;
   logic [1:0]                        bresp;
   logic                              bvalid;
   logic                              bready;

   // read address channel
   logic [C_M_AXI_ID_WIDTH-1:0]       arid;
   logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr;
   logic [7:0]                        arlen;
   logic [2:0]                        arsize;
   logic [1:0]                        arburst;
   logic                              arlock;
   logic [3:0]                        arcache;
   logic [2:0]                        arprot;
   logic [3:0]                        arqos;
   logic [3:0]                        arregion;
   logic                              arvalid;
   logic                              arready;

   // read data channel
   logic [C_M_AXI_ID_WIDTH-1:0]       rid;
   logic [C_M_AXI_DATA_WIDTH-1:0]     rdata;
   logic [1:0]                        rresp;
   logic                              rlast;
   logic                              rvalid;
   logic                              rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_std_master.sv
// AXI4 single-outstanding INCR burst initiator: one command becomes either a
// write burst fed from the wr_* stream or a read burst delivered on rd_*.
// Optional feature macro: AXI_MST_ERR_CHECK_EN enables err/err_resp tracking.
module axi_std_master
   import axi_std_master_pkg::*;
#(
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_M_AXI_ADDR_WIDTH = 10
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETN,

   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_rw,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [7:0]                      cmd_len,
   input  logic [C_M_AXI_ID_WIDTH-1:0]     cmd_id,

   input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
   input  logic                            wr_valid,
   output logic                            wr_ready,

   output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data,
   output logic                            rd_valid,
   input  logic                            rd_ready,
   output logic                            rd_last,

   output logic                            done,
   output logic                            err,
   output logic [1:0]                      err_resp,

   axi_std_master_if.master                m_axi
);

   localparam int                            ADDR_LSB  = $clog2(C_M_AXI_DATA_WIDTH / 8);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_MASK = {C_M_AXI_ADDR_WIDTH{1'b1}} << ADDR_LSB;
   localparam logic [2:0]                    AXI_SIZE  = axi_size(C_M_AXI_DATA_WIDTH);

   axi_mst_state_t                  state;
   axi_mst_state_t                  state_nxt;

   logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]                      len_q;
   logic [C_M_AXI_ID_WIDTH-1:0]     id_q;
   logic [7:0]                      beat_cnt;

   logic                            cmd_hs;
   logic                            w_hs;
   logic                            r_hs;
   logic                            last_beat;

   assign cmd_hs    = (state == IDLE) && cmd_valid;
   assign w_hs      = (state == WDATA) && wr_valid && m_axi.wready;
   assign r_hs      = (state == RDATA) && m_axi.rvalid && rd_ready;
   assign last_beat = (beat_cnt == len_q);

   // address/control fields come straight from the latched command so they stay stable until the handshake
   assign m_axi.awid     = id_q;
   assign m_axi.awaddr   = addr_q;
   assign m_axi.awlen    = len_q;
   assign m_axi.awsize   = AXI_SIZE;
   assign m_axi.awburst  = AXI_BURST_INCR;
   assign m_axi.awlock   = 1'b0;
   assign m_axi.awcache  = AXI_CACHE_DEFAULT;
   assign m_axi.awprot   = 3'b000;
   assign m_axi.awqos    = 4'b0000;
   assign m_axi.awregion = 4'b0000;

   assign m_axi.arid     = id_q;
   assign m_axi.araddr   = addr_q;
   assign m_axi.arlen    = len_q;
   assign m_axi.arsize   = AXI_SIZE;
   assign m_axi.arburst  = AXI_BURST_INCR;
   assign m_axi.arlock   = 1'b0;
   assign m_axi.arcache  = AXI_CACHE_DEFAULT;
   assign m_axi.arprot   = 3'b000;
   assign m_axi.arqos    = 4'b0000;
   assign m_axi.arregion = 4'b0000;

   assign m_axi.wdata    = wr_data;
   assign m_axi.wstrb    = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
   assign rd_data        = m_axi.rdata;

   // state register; reset drops every VALID at once because all of them decode from state
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state and handshake outputs; AW and W phases run strictly one after the other
   always_comb begin
      state_nxt     = state;
      cmd_ready     = 1'b0;
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.wlast   = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      wr_ready      = 1'b0;
      rd_valid      = 1'b0;
      rd_last       = 1'b0;
      done          = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_nxt = cmd_rw ? WADDR : RADDR;
            end
         end
         WADDR: begin
            m_axi.awvalid = 1'b1;
            if (m_axi.awready) begin
               state_nxt = WDATA;
            end
         end
         WDATA: begin
            m_axi.wvalid = wr_valid;
            m_axi.wlast  = last_beat;
            wr_ready     = m_axi.wready;
            if (w_hs && last_beat) begin
               state_nxt = WRESP;
            end
         end
         WRESP: begin
            m_axi.bready = 1'b1;
            if (m_axi.bvalid) begin
               state_nxt = DONE;
            end
         end
         RADDR: begin
            m_axi.arvalid = 1'b1;
            if (m_axi.arready) begin
               state_nxt = RDATA;
            end
         end
         RDATA: begin
            rd_valid     = m_axi.rvalid;
            rd_last      = m_axi.rlast;
            m_axi.rready = rd_ready;
            if (r_hs && m_axi.rlast) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // command latch and beat counter; low address bits are cleared so every burst starts beat-aligned
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         addr_q   <= '0;
         len_q    <= '0;
         id_q     <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               if (cmd_hs) begin
                  addr_q <= cmd_addr & ADDR_MASK;
                  len_q  <= cmd_len;
                  id_q   <= cmd_id;
               end
            end
            WDATA: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            RDATA: begin
               if (r_hs) begin
                  beat_cnt <= beat_cnt + 8'd1;
               end
            end
            default: begin
               beat_cnt <= beat_cnt;
            end
         endcase
      end
   end

`ifdef AXI_MST_ERR_CHECK_EN
   logic       err_q;
   logic [1:0] err_resp_q;
   logic       unused_sigs;

   assign err         = err_q;
   assign err_resp    = err_resp_q;
   assign unused_sigs = &{1'b0, m_axi.bid, m_axi.rid};

   // sticky error: first bad response or RLAST misplacement wins, cleared by the next accepted command
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         err_q      <= 1'b0;
         err_resp_q <= AXI_RESP_OKAY;
      end else if (cmd_hs) begin
         err_q      <= 1'b0;
         err_resp_q <= AXI_RESP_OKAY;
      end else if (!err_q) begin
         if ((state == WRESP) && m_axi.bvalid && (m_axi.bresp != AXI_RESP_OKAY)) begin
            err_q      <= 1'b1;
            err_resp_q <= m_axi.bresp;
         end else if (r_hs) begin
            if (m_axi.rresp != AXI_RESP_OKAY) begin
               err_q      <= 1'b1;
               err_resp_q <= m_axi.rresp;
            end else if ((m_axi.rlast && (beat_cnt < len_q)) || (!m_axi.rlast && last_beat)) begin
               err_q      <= 1'b1;
               err_resp_q <= AXI_RESP_SLVERR;
            end
         end
      end
   end
`else
   logic unused_sigs;

   assign err         = 1'b0;
   assign err_resp    = AXI_RESP_OKAY;
   assign unused_sigs = &{1'b0, m_axi.bid, m_axi.rid, m_axi.bresp, m_axi.rresp};
`endif

endmodule

// File: tb/tb_axi_std_master.sv
// Directed bench for axi_std_master; the AXI slave side is driven cycle by cycle
// from the test tasks. Expectations for err/err_resp follow AXI_MST_ERR_CHECK_EN.
module tb_axi_std_master;

   localparam int IDW = 1;
   localparam int DW  = 512;
   localparam int AW  = 10;

`ifdef AXI_MST_ERR_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic           clk;
   logic           rst_n;
   logic           cmd_valid;
   logic           cmd_ready;
   logic           cmd_rw;
   logic [AW-1:0]  cmd_addr;
   logic [7:0]     cmd_len;
   logic [IDW-1:0] cmd_id;
   logic [DW-1:0]  wr_data;
   logic           wr_valid;
   logic           wr_ready;
   logic [DW-1:0]  rd_data;
   logic           rd_valid;
   logic           rd_ready;
   logic           rd_last;
   logic           done;
   logic           err;
   logic [1:0]     err_resp;

   int passed = 0;
   int total  = 0;

   axi_std_master_if #(
      .C_M_AXI_ID_WIDTH   (IDW),
      .C_M_AXI_DATA_WIDTH (DW),
      .C_M_AXI_ADDR_WIDTH (AW)
   ) bus ();

   axi_std_master #(
      .C_M_AXI_ID_WIDTH   (IDW),
      .C_M_AXI_DATA_WIDTH (DW),
      .C_M_AXI_ADDR_WIDTH (AW)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_rw        (cmd_rw),
      .cmd_addr      (cmd_addr),
      .cmd_len       (cmd_len),
      .cmd_id        (cmd_id),
      .wr_data       (wr_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .rd_last       (rd_last),
      .done          (done),
      .err           (err),
      .err_resp      (err_resp),
      .m_axi         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // sideband constant expected on both AW and AR: size 6 (64B), INCR, cache 0011, rest zero
   logic [20:0] exp_side;
   initial exp_side = {3'd6, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000};

   function automatic logic [DW-1:0] pat(input int n);
      logic [31:0] w;
      w = 32'hC0DE0000 + 32'(n);
      return {16{w}};
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic init_inputs();
      cmd_valid   = 1'b0;
      cmd_rw      = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      cmd_id      = '0;
      wr_data     = '0;
      wr_valid    = 1'b0;
      rd_ready    = 1'b0;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bid     = '0;
      bus.bresp   = 2'b00;
      bus.bvalid  = 1'b0;
      bus.arready = 1'b0;
      bus.rid     = '0;
      bus.rdata   = '0;
      bus.rresp   = 2'b00;
      bus.rlast   = 1'b0;
      bus.rvalid  = 1'b0;
   endtask

   // presents one command for a single cycle; returns at the negedge with the DUT in WADDR/RADDR
   task automatic send_cmd(input logic rw, input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_id    = id;
      #1;
      total++;
      if (cmd_ready !== 1'b1) $display("[TB] FAIL cmd_ready_at_issue: got %b expected 1", cmd_ready);
      else passed++;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      init_inputs();
      step();
      #1;
      total++;
      if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      else passed++;
      total++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, wr_ready, rd_valid, rd_last} !== 8'h00)
         $display("[TB] FAIL reset_handshakes: got %b expected 00000000",
                  {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, wr_ready, rd_valid, rd_last});
      else passed++;
      total++;
      if ({done, err, err_resp} !== 4'b0000) $display("[TB] FAIL reset_status: got %b expected 0000", {done, err, err_resp});
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      #1;
      total++;
      if ({cmd_ready, done} !== 2'b10) $display("[TB] FAIL post_reset_idle: got %b expected 10", {cmd_ready, done});
      else passed++;
   endtask

   task automatic test_write_burst();
      send_cmd(1'b1, 10'h000, 8'd3, 1'b1);
      #1;
      total++;
      if ({bus.awvalid, bus.awaddr, bus.awlen, bus.awid} !== {1'b1, 10'h000, 8'd3, 1'b1})
         $display("[TB] FAIL wr_aw_fields: got %h expected %h", {bus.awvalid, bus.awaddr, bus.awlen, bus.awid},
                  {1'b1, 10'h000, 8'd3, 1'b1});
      else passed++;
      total++;
      if ({bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.awqos, bus.awregion} !== exp_side)
         $display("[TB] FAIL wr_aw_sideband: got %h expected %h",
                  {bus.awsize, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.awqos, bus.awregion}, exp_side);
      else passed++;
      total++;
      if ({bus.wvalid, cmd_ready} !== 2'b00) $display("[TB] FAIL wr_no_overlap: got %b expected 00", {bus.wvalid, cmd_ready});
      else passed++;
      bus.awready = 1'b1;
      wr_valid    = 1'b1;
      wr_data     = pat(0);
      step();
      bus.awready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_valid   = 1'b1;
         wr_data    = pat(i);
         bus.wready = 1'b1;
         bus.bvalid = (i == 1);
         #1;
         total++;
         if ({bus.wvalid, bus.wlast, wr_ready, bus.bready, bus.awvalid} !== {1'b1, (i == 3), 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL wr_beat%0d_ctrl: got %b expected %b", i,
                     {bus.wvalid, bus.wlast, wr_ready, bus.bready, bus.awvalid}, {1'b1, (i == 3), 1'b1, 1'b0, 1'b0});
         else passed++;
         total++;
         if (bus.wdata !== pat(i)) $display("[TB] FAIL wr_beat%0d_data: got %h expected %h", i, bus.wdata, pat(i));
         else passed++;
         step();
      end
      total++;
      if (bus.wstrb !== {64{1'b1}}) $display("[TB] FAIL wr_wstrb: got %h expected all ones", bus.wstrb);
      else passed++;
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b00;
      #1;
      total++;
      if ({bus.bready, bus.wvalid, done} !== 3'b100) $display("[TB] FAIL wr_bresp_phase: got %b expected 100", {bus.bready, bus.wvalid, done});
      else passed++;
      step();
      bus.bvalid = 1'b0;
      #1;
      total++;
      if ({done, cmd_ready, bus.bready} !== 3'b100) $display("[TB] FAIL wr_done_pulse: got %b expected 100", {done, cmd_ready, bus.bready});
      else passed++;
      step();
      #1;
      total++;
      if ({done, cmd_ready, err} !== 3'b010) $display("[TB] FAIL wr_back_idle: got %b expected 010", {done, cmd_ready, err});
      else passed++;
   endtask

   task automatic test_read_burst();
      send_cmd(1'b0, 10'h07F, 8'd3, 1'b0);
      for (int s = 0; s < 2; s++) begin
         #1;
         total++;
         if ({bus.arvalid, bus.araddr, bus.arlen, bus.awvalid} !== {1'b1, 10'h040, 8'd3, 1'b0})
            $display("[TB] FAIL rd_ar_hold%0d: got %h expected %h", s, {bus.arvalid, bus.araddr, bus.arlen, bus.awvalid},
                     {1'b1, 10'h040, 8'd3, 1'b0});
         else passed++;
         step();
      end
      total++;
      if ({bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arregion} !== exp_side)
         $display("[TB] FAIL rd_ar_sideband: got %h expected %h",
                  {bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.arqos, bus.arregion}, exp_side);
      else passed++;
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.rvalid = 1'b1;
         bus.rdata  = pat(16 + i);
         bus.rlast  = (i == 3);
         bus.rresp  = 2'b00;
         rd_ready   = 1'b1;
         #1;
         total++;
         if ({rd_valid, rd_last, bus.rready, done} !== {1'b1, (i == 3), 1'b1, 1'b0})
            $display("[TB] FAIL rd_beat%0d_ctrl: got %b expected %b", i, {rd_valid, rd_last, bus.rready, done},
                     {1'b1, (i == 3), 1'b1, 1'b0});
         else passed++;
         total++;
         if (rd_data !== pat(16 + i)) $display("[TB] FAIL rd_beat%0d_data: got %h expected %h", i, rd_data, pat(16 + i));
         else passed++;
         step();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      rd_ready   = 1'b0;
      #1;
      total++;
      if ({done, err, err_resp, rd_valid} !== 5'b10000) $display("[TB] FAIL rd_done: got %b expected 10000", {done, err, err_resp, rd_valid});
      else passed++;
      step();
      #1;
      total++;
      if ({done, cmd_ready} !== 2'b01) $display("[TB] FAIL rd_back_idle: got %b expected 01", {done, cmd_ready});
      else passed++;
   endtask

   task automatic test_len0_stall();
      send_cmd(1'b1, 10'h0C0, 8'd0, 1'b0);
      bus.awready = 1'b1;
      #1;
      total++;
      if ({bus.awaddr, bus.awlen} !== {10'h0C0, 8'd0}) $display("[TB] FAIL len0_aw: got %h expected %h", {bus.awaddr, bus.awlen}, {10'h0C0, 8'd0});
      else passed++;
      step();
      bus.awready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         wr_valid   = 1'b1;
         wr_data    = pat(85);
         bus.wready = 1'b0;
         #1;
         total++;
         if ({bus.wvalid, bus.wlast, wr_ready} !== 3'b110 || bus.wdata !== pat(85))
            $display("[TB] FAIL len0_stall%0d: got ctl %b data %h expected ctl 110 data %h", s,
                     {bus.wvalid, bus.wlast, wr_ready}, bus.wdata, pat(85));
         else passed++;
         step();
      end
      bus.wready = 1'b1;
      #1;
      total++;
      if ({bus.wvalid, bus.wlast, wr_ready} !== 3'b111) $display("[TB] FAIL len0_accept: got %b expected 111", {bus.wvalid, bus.wlast, wr_ready});
      else passed++;
      step();
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      bus.bvalid = 1'b1;
      #1;
      total++;
      if ({bus.bready, bus.wvalid} !== 2'b10) $display("[TB] FAIL len0_single_beat: got %b expected 10", {bus.bready, bus.wvalid});
      else passed++;
      step();
      bus.bvalid = 1'b0;
      #1;
      total++;
      if (done !== 1'b1) $display("[TB] FAIL len0_done: got %b expected 1", done);
      else passed++;
      step();
   endtask

   task automatic test_rd_toggle();
      int k;
      k = 0;
      send_cmd(1'b0, 10'h100, 8'd7, 1'b1);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
         bus.rvalid = 1'b1;
         bus.rdata  = pat(32 + k);
         bus.rlast  = (k == 7);
         bus.rresp  = 2'b00;
         rd_ready   = (cyc % 2 == 0);
         #1;
         total++;
         if ({bus.rready, rd_valid, done} !== {rd_ready, 1'b1, 1'b0})
            $display("[TB] FAIL toggle_cyc%0d_ctrl: got %b expected %b", cyc, {bus.rready, rd_valid, done}, {rd_ready, 1'b1, 1'b0});
         else passed++;
         if (rd_ready) begin
            total++;
            if (rd_data !== pat(32 + k) || rd_last !== (k == 7))
               $display("[TB] FAIL toggle_beat%0d: got last %b data %h expected last %b data %h", k, rd_last, rd_data,
                        (k == 7), pat(32 + k));
            else passed++;
            k++;
         end
         step();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      rd_ready   = 1'b0;
      #1;
      total++;
      if (k != 8 || done !== 1'b1) $display("[TB] FAIL toggle_done: got beats %0d done %b expected beats 8 done 1", k, done);
      else passed++;
      step();
   endtask

   task automatic test_bresp_err();
      send_cmd(1'b1, 10'h000, 8'd0, 1'b0);
      bus.awready = 1'b1;
      step();
      bus.awready = 1'b0;
      wr_valid    = 1'b1;
      wr_data     = pat(99);
      bus.wready  = 1'b1;
      step();
      wr_valid    = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b1;
      bus.bresp   = 2'b10;
      step();
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      #1;
      total++;
      if ({done, err, err_resp} !== {1'b1, ERR_ON, ERR_ON, 1'b0})
         $display("[TB] FAIL bresp_err_set: got %b expected %b", {done, err, err_resp}, {1'b1, ERR_ON, ERR_ON, 1'b0});
      else passed++;
      step();
      #1;
      total++;
      if ({err, err_resp} !== {ERR_ON, ERR_ON, 1'b0})
         $display("[TB] FAIL bresp_err_sticky: got %b expected %b", {err, err_resp}, {ERR_ON, ERR_ON, 1'b0});
      else passed++;
      send_cmd(1'b0, 10'h040, 8'd0, 1'b0);
      #1;
      total++;
      if ({err, err_resp} !== 3'b000) $display("[TB] FAIL bresp_err_clear: got %b expected 000", {err, err_resp});
      else passed++;
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rlast   = 1'b1;
      bus.rdata   = pat(7);
      rd_ready    = 1'b1;
      step();
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      rd_ready    = 1'b0;
      #1;
      total++;
      if ({done, err} !== 2'b10) $display("[TB] FAIL clean_read_after_err: got %b expected 10", {done, err});
      else passed++;
      step();
   endtask

   task automatic test_rlast_early();
      send_cmd(1'b0, 10'h080, 8'd1, 1'b0);
      bus.arready = 1'b1;
      step();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rlast   = 1'b1;
      bus.rdata   = pat(3);
      rd_ready    = 1'b1;
      step();
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      rd_ready    = 1'b0;
      #1;
      total++;
      if ({done, err, err_resp} !== {1'b1, ERR_ON, ERR_ON, 1'b0})
         $display("[TB] FAIL rlast_early: got %b expected %b", {done, err, err_resp}, {1'b1, ERR_ON, ERR_ON, 1'b0});
      else passed++;
      step();
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b1, 10'h000, 8'd3, 1'b1);
      bus.awready = 1'b1;
      step();
      bus.awready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_valid   = 1'b1;
         wr_data    = pat(64 + i);
         bus.wready = 1'b1;
         step();
      end
      wr_data = pat(66);
      #1;
      total++;
      if ({bus.wvalid, bus.wlast} !== 2'b10) $display("[TB] FAIL mid_beat2_live: got %b expected 10", {bus.wvalid, bus.wlast});
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, wr_ready, done} !== 7'b0000000)
         $display("[TB] FAIL mid_reset_drop: got %b expected 0000000",
                  {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, wr_ready, done});
      else passed++;
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      #1;
      total++;
      if ({cmd_ready, err, bus.wvalid} !== 3'b100) $display("[TB] FAIL mid_reset_release: got %b expected 100", {cmd_ready, err, bus.wvalid});
      else passed++;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n = 1'b0;
      init_inputs();
      test_reset();
      test_write_burst();
      test_read_burst();
      test_len0_stall();
      test_rd_toggle();
      test_bresp_err();
      test_rlast_early();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
